spi_slave: RTL and testbench

//  SPI responder (mode 0, MSB first) for the alarm-system SPI link; the slave-side counterpart of the existing SPI master.

---
 rtl/spi_slave_pkg.sv | 14 +
 rtl/spi_slave_sync_edge.sv | 35 +++
 rtl/spi_slave.sv | 159 +++++++++++++++
 tb/tb_spi_slave.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave.
// Holds the FSM state encodings and the default frame length.
// The encodings and the frame length match the ones used by the SPI master.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    SPI_IDLE  = 2'd0,
    SPI_SHIFT = 2'd1,
    SPI_DONE  = 2'd2
  } spi_state_t;

  localparam int SPI_DEFAULT_BITS = 16;

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Synchronizer plus edge detector for one asynchronous SPI input.
// The synchronizer is a chain of sync_stages flops.
// rise and fall are single-cycle pulses derived from the synchronized copy.
// Every flop clears to 0. After reset, a line that is already high therefore
// shows a rise, which is harmless. A line that is already low shows no false fall.
module spi_sync_edge #(
  parameter int sync_stages = 2
) (
  input  logic CLOCK_50,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [sync_stages-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw input through the synchronizer and keep one cycle of history for edge detection
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[sync_stages-2:0], async_in};
      prev_q <= sync_q[sync_stages-1];
    end
  end

  assign sync_out = sync_q[sync_stages-1];
  assign rise     = sync_out & ~prev_q;
  assign fall     = ~sync_out & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: mode 0, MSB first, one frame of bits_transfer bits per ss_n assertion.
// The SPI inputs are oversampled on CLOCK_50.
// The module offers a parallel TX load handshake and a one-cycle RX valid strobe.
// Optional feature: define SPI_SLAVE_FRAME_ERR_EN to get a one-cycle frame_err pulse on aborted frames.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int bits_transfer = SPI_DEFAULT_BITS,
  parameter int counter_width = $clog2(bits_transfer) + 1,
  parameter int sync_stages   = 2
) (
  input  logic                     CLOCK_50,
  input  logic                     rst,
  input  logic                     spi_sclk,
  input  logic                     spi_ss_n,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  input  logic [bits_transfer-1:0] tx_data,
  input  logic                     tx_load,
  output logic                     tx_ready,
  output logic [bits_transfer-1:0] rx_data,
  output logic                     rx_valid,
  output logic                     busy,
  output logic                     frame_err
);

  localparam logic [counter_width-1:0] FULL_COUNT = counter_width'(bits_transfer);

  spi_state_t               state;
  spi_state_t               next_state;
  logic [counter_width-1:0] bit_count;
  logic [bits_transfer-1:0] rx_shift;
  logic [bits_transfer-1:0] tx_shift;
  logic [bits_transfer-1:0] tx_buf;
  logic [bits_transfer-1:0] tx_word_next;
  logic                     load_accept;

  logic sclk_sync, sclk_rise, sclk_fall;
  logic ss_sync, ss_rise, ss_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic unused_sync_bits;

  spi_sync_edge #(.sync_stages(sync_stages)) u_sclk_sync (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .async_in (spi_sclk),
    .sync_out (sclk_sync),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  spi_sync_edge #(.sync_stages(sync_stages)) u_ss_sync (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .async_in (spi_ss_n),
    .sync_out (ss_sync),
    .rise     (ss_rise),
    .fall     (ss_fall)
  );

  spi_sync_edge #(.sync_stages(sync_stages)) u_mosi_sync (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .async_in (spi_mosi),
    .sync_out (mosi_sync),
    .rise     (mosi_rise),
    .fall     (mosi_fall)
  );

  assign unused_sync_bits = sclk_sync ^ ss_sync ^ mosi_rise ^ mosi_fall;

  // Loads are only taken between frames.
  // A load that coincides with frame start is forwarded straight into the shifter.
  assign tx_ready     = (state == SPI_IDLE);
  assign load_accept  = tx_load & tx_ready;
  assign tx_word_next = load_accept ? tx_data : tx_buf;

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (rst) state <= SPI_IDLE;
    else     state <= next_state;
  end

  // Next-state logic: frame start on ss_n fall, completion on full bit count, abort on early ss_n rise
  always_comb begin
    next_state = state;
    case (state)
      SPI_IDLE:  if (ss_fall) next_state = SPI_SHIFT;
      SPI_SHIFT: begin
        if (ss_rise && (bit_count < FULL_COUNT)) next_state = SPI_IDLE;
        else if (bit_count == FULL_COUNT)        next_state = SPI_DONE;
      end
      SPI_DONE:  next_state = SPI_IDLE;
      default:   next_state = SPI_IDLE;
    endcase
  end

  // Datapath: TX buffer, shift registers, bit counter, MISO driver and the RX word/strobe
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      tx_buf    <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_count <= '0;
      spi_miso  <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (load_accept) tx_buf <= tx_data;
      case (state)
        SPI_IDLE: begin
          if (ss_fall) begin
            tx_shift  <= tx_word_next;
            spi_miso  <= tx_word_next[bits_transfer-1];
            bit_count <= '0;
            rx_shift  <= '0;
            busy      <= 1'b1;
          end
        end
        SPI_SHIFT: begin
          if (next_state == SPI_IDLE) begin
            busy <= 1'b0;
          end else if (next_state == SPI_DONE) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
            busy     <= 1'b0;
          end else begin
            if (sclk_rise && (bit_count < FULL_COUNT)) begin
              rx_shift  <= {rx_shift[bits_transfer-2:0], mosi_sync};
              bit_count <= bit_count + counter_width'(1);
            end
            if (sclk_fall && (bit_count < FULL_COUNT)) begin
              tx_shift <= {tx_shift[bits_transfer-2:0], 1'b0};
              spi_miso <= tx_shift[bits_transfer-2];
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic frame_err_q;

  // Flag an abort that happens after at least one bit was received; the pulse lines up with busy falling
  always_ff @(posedge CLOCK_50) begin
    if (rst) frame_err_q <= 1'b0;
    else     frame_err_q <= (state == SPI_SHIFT) && (next_state == SPI_IDLE) && (bit_count != '0);
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave.
// A table of frames is driven by a mode-0 master model.
// Hand-written sequences cover abort, reset mid-frame and SCLK activity while deselected.
// The bench follows SPI_SLAVE_FRAME_ERR_EN when that macro is defined.
module tb_spi_slave;

  localparam int HALF = 8;

`ifdef SPI_SLAVE_FRAME_ERR_EN
  localparam int EXP_ABORT_ERR = 1;
`else
  localparam int EXP_ABORT_ERR = 0;
`endif

  logic        CLOCK_50;
  logic        rst;
  logic        spi_sclk;
  logic        spi_ss_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic [15:0] tx_data;
  logic        tx_load;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        busy;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int rxValidCount = 0;
  int frameErrCount = 0;

  // loadMode: 0 none, 1 load before frame, 2 load mid-frame, 3 load in the cycle the frame starts
  typedef struct {
    int          loadMode;
    logic [15:0] loadWord;
    logic [15:0] mosiWord;
    logic [15:0] expMiso;
    logic [15:0] expRx;
  } vec_t;

  vec_t vecs[7];

  spi_slave dut (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .spi_sclk  (spi_sclk),
    .spi_ss_n  (spi_ss_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .frame_err (frame_err)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // Count the cycles in which each strobe is high, sampled away from the active edge
  always @(negedge CLOCK_50) begin
    if (rx_valid)  rxValidCount++;
    if (frame_err) frameErrCount++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic pulseLoad(input logic [15:0] word, input string name);
    checkOutput(name, tx_ready, 1'b1);
    tx_data = word;
    tx_load = 1'b1;
    waitCycles(1);
    tx_load = 1'b0;
  endtask

  // Mode-0 master model: sample MISO before each rising edge, change MOSI after each falling edge
  task automatic applyStimulus(input logic [15:0] mosiWord, input int nRise, input int loadMode,
                               input logic [15:0] loadWord, output logic [15:0] misoWord);
    misoWord = '0;
    spi_ss_n = 1'b0;
    spi_mosi = mosiWord[15];
    if (loadMode == 3) begin
      waitCycles(2);
      pulseLoad(loadWord, "tx_ready_at_start");
      waitCycles(HALF - 3);
    end else begin
      waitCycles(HALF);
    end
    for (int i = 0; i < nRise; i++) begin
      misoWord[15-i] = spi_miso;
      spi_sclk = 1'b1;
      waitCycles(HALF);
      if (loadMode == 2 && i == 7) begin
        checkOutput("tx_ready_mid", tx_ready, 1'b0);
        checkOutput("busy_mid", busy, 1'b1);
        tx_data = loadWord;
        tx_load = 1'b1;
        waitCycles(1);
        tx_load = 1'b0;
      end
      spi_sclk = 1'b0;
      if (i < 15) spi_mosi = mosiWord[14-i];
      waitCycles(HALF);
    end
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    waitCycles(12);
  endtask

  initial begin
    logic [15:0] misoWord;
    int          validBefore;
    int          errBefore;
    logic [15:0] rxBefore;
    bit          busySeen;

    vecs[0] = '{1, 16'hBEEF, 16'hDEAD, 16'hBEEF, 16'hDEAD};
    vecs[1] = '{0, 16'h0000, 16'h1234, 16'hBEEF, 16'h1234};
    vecs[2] = '{0, 16'h0000, 16'h5678, 16'hBEEF, 16'h5678};
    vecs[3] = '{2, 16'h0F0F, 16'hA5A5, 16'hBEEF, 16'hA5A5};
    vecs[4] = '{0, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
    vecs[5] = '{1, 16'h8001, 16'hFFFF, 16'h8001, 16'hFFFF};
    vecs[6] = '{3, 16'hC3A5, 16'h0F0F, 16'hC3A5, 16'h0F0F};

    rst      = 1'b1;
    spi_sclk = 1'b0;
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    tx_data  = '0;
    tx_load  = 1'b0;
    waitCycles(4);
    checkOutput("reset_miso", spi_miso, 1'b0);
    checkOutput("reset_tx_ready", tx_ready, 1'b1);
    checkOutput("reset_rx_data", rx_data, 16'h0000);
    checkOutput("reset_rx_valid", rx_valid, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    waitCycles(10);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].loadMode == 1) pulseLoad(vecs[v].loadWord, "tx_ready_idle");
      validBefore = rxValidCount;
      errBefore   = frameErrCount;
      applyStimulus(vecs[v].mosiWord, 16, vecs[v].loadMode, vecs[v].loadWord, misoWord);
      checkOutput($sformatf("miso_word_%0d", v), misoWord, vecs[v].expMiso);
      checkOutput($sformatf("rx_data_%0d", v), rx_data, vecs[v].expRx);
      checkOutput($sformatf("rx_valid_pulses_%0d", v), rxValidCount - validBefore, 1);
      checkOutput($sformatf("frame_err_%0d", v), frameErrCount - errBefore, 0);
      checkOutput($sformatf("busy_after_%0d", v), busy, 1'b0);
    end

    // Abort after 7 rising edges
    rxBefore    = rx_data;
    validBefore = rxValidCount;
    errBefore   = frameErrCount;
    applyStimulus(16'hFFFF, 7, 0, 16'h0000, misoWord);
    checkOutput("abort_rx_data", rx_data, rxBefore);
    checkOutput("abort_rx_valid", rxValidCount - validBefore, 0);
    checkOutput("abort_frame_err", frameErrCount - errBefore, EXP_ABORT_ERR);
    checkOutput("abort_busy", busy, 1'b0);

    // Reset in the middle of a frame
    spi_ss_n = 1'b0;
    spi_mosi = 1'b1;
    waitCycles(HALF);
    for (int i = 0; i < 5; i++) begin
      spi_sclk = 1'b1;
      waitCycles(HALF);
      spi_sclk = 1'b0;
      waitCycles(HALF);
    end
    checkOutput("pre_reset_busy", busy, 1'b1);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_rx_data", rx_data, 16'h0000);
    checkOutput("rst_miso", spi_miso, 1'b0);
    checkOutput("rst_tx_ready", tx_ready, 1'b1);
    rst = 1'b0;
    waitCycles(10);
    checkOutput("rst_no_restart", busy, 1'b0);
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    waitCycles(10);
    validBefore = rxValidCount;
    applyStimulus(16'h9669, 16, 0, 16'h0000, misoWord);
    checkOutput("post_rst_miso", misoWord, 16'h0000);
    checkOutput("post_rst_rx_data", rx_data, 16'h9669);
    checkOutput("post_rst_rx_valid", rxValidCount - validBefore, 1);

    // SCLK activity while deselected must be ignored
    rxBefore    = rx_data;
    validBefore = rxValidCount;
    busySeen    = 1'b0;
    spi_ss_n    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      spi_mosi = i[0];
      spi_sclk = 1'b1;
      waitCycles(HALF);
      if (busy || !tx_ready) busySeen = 1'b1;
      spi_sclk = 1'b0;
      waitCycles(HALF);
      if (busy || !tx_ready) busySeen = 1'b1;
    end
    checkOutput("desel_busy", busySeen, 1'b0);
    checkOutput("desel_rx_valid", rxValidCount - validBefore, 0);
    checkOutput("desel_rx_data", rx_data, rxBefore);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
